// File: rtl/rca_multiword_sequencer.sv
// Multi-precision adder: one 8-bit ripple-carry adder reused across NLIMBS byte limbs, LSB limb first.
// Optional subtract mode is compiled in with `define RCA_SEQ_SUB_EN (adds the 'sub' input).
module rca_multiword_sequencer #(
    parameter int NLIMBS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*NLIMBS-1:0] a_in,
    input  logic [8*NLIMBS-1:0] b_in,
    input  logic                cin,
`ifdef RCA_SEQ_SUB_EN
    input  logic                sub,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NLIMBS-1:0] sum_out,
    output logic                cout,
    output logic                busy
);
    localparam int W     = 8 * NLIMBS;
    localparam int IDX_W = $clog2(NLIMBS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NLIMBS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     sum_q;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic             cout_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [7:0]       a_limb;
    logic [7:0]       b_limb;
    logic [7:0]       limb_sum;
    logic             limb_cout;
    logic [W-1:0]     b_cap;
    logic             carry_cap;

`ifdef RCA_SEQ_SUB_EN
    // Subtract as A + ~B + 1; the inversion is applied once at capture time.
    assign b_cap     = sub ? ~b_in : b_in;
    assign carry_cap = sub ? 1'b1 : cin;
`else
    assign b_cap     = b_in;
    assign carry_cap = cin;
`endif

    always_comb begin
        a_limb = '0;
        b_limb = '0;
        for (int i = 0; i < NLIMBS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_limb = a_q[8*i +: 8];
                b_limb = b_q[8*i +: 8];
            end
        end
    end

    ripple_carry_adder u_adder (
        .a_i    (a_limb),
        .b_i    (b_limb),
        .cin_i  (carry_q),
        .sum_o  (limb_sum),
        .cout_o (limb_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a_in;
                        b_q        <= b_cap;
                        carry_q    <= carry_cap;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NLIMBS; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            sum_q[8*i +: 8] <= limb_sum;
                        end
                    end
                    carry_q <= limb_cout;
                    if (idx_q == LAST_IDX) begin
                        cout_q      <= limb_cout;
                        idx_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    // Result stays on sum_out/cout after the handshake until the next limb-0 write.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum_out   = sum_q;
    assign cout      = cout_q;
    assign busy      = busy_q;

endmodule

// 8-bit ripple-carry adder shared by every limb of the sequencer.
module ripple_carry_adder (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       cin_i,
    output logic [7:0] sum_o,
    output logic       cout_o
);
    logic [8:0] c;

    always_comb begin
        c     = '0;
        sum_o = '0;
        c[0]  = cin_i;
        for (int i = 0; i < 8; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
        cout_o = c[8];
    end

endmodule

// File: tb/tb_rca_multiword_sequencer.sv
// Self-checking bench for rca_multiword_sequencer: directed corner cases plus random operands.
module tb_rca_multiword_sequencer;
    localparam int NLIMBS = 4;
    localparam int W      = 8 * NLIMBS;

    logic         clk       = 1'b0;
    logic         rst       = 1'b1;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] a_in      = '0;
    logic [W-1:0] b_in      = '0;
    logic         cin       = 1'b0;
    logic         sub       = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum_out;
    logic         cout;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rca_multiword_sequencer #(.NLIMBS(NLIMBS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .cin       (cin),
`ifdef RCA_SEQ_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_out   (sum_out),
        .cout      (cout),
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain (W+1)-bit arithmetic; subtract is A + ~B + 1.
    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c, input logic s);
        logic [W:0] r;
        if (s) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else   r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        return r;
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic s, input int hold, input logic press,
                          input logic [W-1:0] a2, input logic [W-1:0] b2);
        logic [W:0] exp;
        int guard;
        int lat;
        exp = ref_add(a, b, c, s);
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_eq("in_ready_idle", in_ready, 1);
        a_in = a; b_in = b; cin = c; sub = s; in_valid = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs after the accept edge; the captured operands must win.
        in_valid = 1'b0;
        a_in = W'($urandom); b_in = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        check_eq("busy_run", busy, 1);
        check_eq("in_ready_run", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < NLIMBS + 4) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("latency", lat, NLIMBS);
        check_eq("sum", sum_out, exp[W-1:0]);
        check_eq("cout", cout, exp[W]);
        check_eq("busy_done", busy, 1);
        for (int h = 0; h < hold; h++) begin
            if (press) begin
                in_valid = 1'b1; a_in = a2; b_in = b2; cin = 1'b0; sub = 1'b0;
            end
            @(posedge clk);
            #1;
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_sum", sum_out, exp[W-1:0]);
            check_eq("hold_cout", cout, exp[W]);
            check_eq("hold_in_ready", in_ready, 0);
            check_eq("hold_busy", busy, 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("valid_drop", out_valid, 0);
        check_eq("in_ready_back", in_ready, 1);
        check_eq("busy_idle", busy, 0);
        check_eq("sum_persist", sum_out, exp[W-1:0]);
        check_eq("cout_persist", cout, exp[W]);
    endtask

    initial begin
        #1;
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_sum", sum_out, 0);
        check_eq("rst_cout", cout, 0);
        check_eq("rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("post_rst_in_ready", in_ready, 1);

        run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 0, 1'b0, '0, '0);
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 0, 1'b0, '0, '0);
        run_op(32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0, 0, 1'b0, '0, '0);
        run_op(32'hF0F0F0F0, 32'h0F0F0F0F, 1'b0, 1'b0, 0, 1'b0, '0, '0);

        // Backpressure: second operand set offered during DONE must wait for IDLE.
        run_op(32'h01020304, 32'h10203040, 1'b1, 1'b0, 6, 1'b1, 32'h89ABCDEF, 32'h76543211);
        run_op(32'h89ABCDEF, 32'h76543211, 1'b0, 1'b0, 0, 1'b0, '0, '0);

        // Asynchronous reset two cycles into RUN.
        @(negedge clk);
        a_in = 32'h12345678; b_in = 32'h11111111; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_in_ready", in_ready, 0);
        check_eq("mid_rst_out_valid", out_valid, 0);
        check_eq("mid_rst_sum", sum_out, 0);
        check_eq("mid_rst_cout", cout, 0);
        check_eq("mid_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mid_rst_release_ready", in_ready, 1);
        run_op(32'h00000001, 32'h00000001, 1'b0, 1'b0, 0, 1'b0, '0, '0);

`ifdef RCA_SEQ_SUB_EN
        run_op(32'h00000000, 32'h00000001, 1'b1, 1'b1, 0, 1'b0, '0, '0);
        run_op(32'h00000100, 32'h00000001, 1'b0, 1'b1, 2, 1'b0, '0, '0);
`endif

        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            logic         rs;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
`ifdef RCA_SEQ_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            run_op(ra, rb, rc, rs, int'($urandom_range(0, 3)), 1'b0, '0, '0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

endmodule
